// File: rtl/if_stage_mo.sv
// if_stage_mo: multi-outstanding instruction-fetch stage.
// Issues in-order requests on the SRAM-like instruction port and keeps the
// fetch addresses in a small in-flight queue. Returned instructions go into
// an instruction buffer that feeds ID. After a redirect, responses that are
// still in flight are counted and dropped as they come back.
// Optional feature: define IF_PERF_CNT_EN to add the perf_fetch_cnt and
// perf_drop_cnt counters and their output ports.
module if_stage_mo #(
    parameter logic [31:0] PC_RESET        = 32'h1C00_0000,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned IBUF_DEPTH      = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ds_allowin,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        wb_ex,
    input  logic        wb_ertn,
    input  logic [31:0] csr_eentry,
    input  logic [31:0] csr_era,
    output logic        fs_to_ds_valid,
    output logic [64:0] fs_to_ds_bus,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
`ifdef IF_PERF_CNT_EN
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_drop_cnt,
`endif
    input  logic [31:0] inst_sram_rdata
);

    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned CW = $clog2(IBUF_DEPTH + 1);
    localparam int unsigned FW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
    localparam int unsigned QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned BW = 65;

    // State
    logic [31:0]   fetch_pc;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] discard;
    logic          adef_stop;
    logic          stale_pending;

    logic [BW-1:0] fifo_mem [IBUF_DEPTH];
    logic [FW-1:0] fifo_rd;
    logic [FW-1:0] fifo_wr;
    logic [CW-1:0] fifo_cnt;

    logic [31:0]   pcq_mem [MAX_OUTSTANDING];
    logic [QW-1:0] pcq_rd;
    logic [QW-1:0] pcq_wr;

    // Next-state / decode
    logic          hs;
    logic          redirect;
    logic [31:0]   target;
    logic          live_hs;
    logic          drop;
    logic          live_data;
    logic          pop;
    logic          adef_push;
    logic          push;
    logic [BW-1:0] push_data;
    logic [OW-1:0] outstanding_n;
    logic [OW-1:0] discard_n;
    logic [31:0]   fetch_pc_n;
    logic          adef_stop_n;
    logic [CW-1:0] fifo_cnt_n;
    logic          pending_n;
    logic          stale_n;
    logic          room_n;
    logic          req_n;
    logic [31:0]   addr_n;

    function automatic logic [FW-1:0] fifo_inc(input logic [FW-1:0] p);
        return (32'(p) == IBUF_DEPTH - 1) ? '0 : FW'(32'(p) + 32'd1);
    endfunction

    function automatic logic [QW-1:0] pcq_inc(input logic [QW-1:0] p);
        return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : QW'(32'(p) + 32'd1);
    endfunction

    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = 4'b0000;
    assign inst_sram_wdata = 32'h0;

    assign fs_to_ds_valid = (fifo_cnt != '0);
    assign fs_to_ds_bus   = fifo_mem[fifo_rd];

    // Handshake decode, redirect handling and next values of all control state
    always_comb begin
        hs        = inst_sram_req & inst_sram_addr_ok;
        redirect  = wb_ex | wb_ertn | br_taken;
        target    = br_target;
        if (wb_ex) begin
            target = csr_eentry;
        end else if (wb_ertn) begin
            target = csr_era;
        end

        // A handshake is live only if it belongs to the current fetch stream
        live_hs   = hs & ~stale_pending & ~redirect;
        drop      = inst_sram_data_ok & (discard != '0);
        live_data = inst_sram_data_ok & (discard == '0);
        pop       = fs_to_ds_valid & ds_allowin;

        // Misaligned fetch: wait for the bus to go quiet, then hand ID a marker entry
        adef_push = ~redirect & ~adef_stop & (fetch_pc[1:0] != 2'b00)
                  & (outstanding == '0) & (discard == '0) & ~inst_sram_req
                  & (32'(fifo_cnt) < IBUF_DEPTH);
        push      = ~redirect & (live_data | adef_push);
        push_data = adef_push ? {1'b1, 32'h0, fetch_pc}
                              : {1'b0, inst_sram_rdata, pcq_mem[pcq_rd]};

        outstanding_n = outstanding + OW'(hs) - OW'(inst_sram_data_ok);
        // Everything still in flight after a redirect is stale
        if (redirect) begin
            discard_n = outstanding_n;
        end else begin
            discard_n = discard + OW'(hs & stale_pending) - OW'(drop);
        end

        fetch_pc_n = fetch_pc;
        if (redirect) begin
            fetch_pc_n = target;
        end else if (live_hs) begin
            fetch_pc_n = fetch_pc + 32'd4;
        end

        adef_stop_n = redirect ? 1'b0 : (adef_stop | adef_push);
        fifo_cnt_n  = redirect ? '0 : (fifo_cnt + CW'(push) - CW'(pop));

        // A request not yet accepted keeps its address, even across a redirect
        pending_n = inst_sram_req & ~inst_sram_addr_ok;
        stale_n   = pending_n & (stale_pending | redirect);
        room_n    = (32'(fifo_cnt_n) + 32'(outstanding_n)) < IBUF_DEPTH;
        req_n     = pending_n
                  | (~adef_stop_n & (32'(outstanding_n) < MAX_OUTSTANDING)
                     & room_n & (fetch_pc_n[1:0] == 2'b00));
        addr_n    = pending_n ? inst_sram_addr : fetch_pc_n;
    end

    // Control registers and request outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc       <= PC_RESET;
            outstanding    <= '0;
            discard        <= '0;
            adef_stop      <= 1'b0;
            stale_pending  <= 1'b0;
            fifo_cnt       <= '0;
            fifo_rd        <= '0;
            fifo_wr        <= '0;
            pcq_rd         <= '0;
            pcq_wr         <= '0;
            inst_sram_req  <= 1'b0;
            inst_sram_addr <= 32'h0;
        end else begin
            fetch_pc       <= fetch_pc_n;
            outstanding    <= outstanding_n;
            discard        <= discard_n;
            adef_stop      <= adef_stop_n;
            stale_pending  <= stale_n;
            fifo_cnt       <= fifo_cnt_n;
            inst_sram_req  <= req_n;
            inst_sram_addr <= addr_n;
            if (redirect) begin
                fifo_rd <= '0;
                fifo_wr <= '0;
                pcq_rd  <= '0;
                pcq_wr  <= '0;
            end else begin
                if (push) begin
                    fifo_wr <= fifo_inc(fifo_wr);
                end
                if (pop) begin
                    fifo_rd <= fifo_inc(fifo_rd);
                end
                if (live_hs) begin
                    pcq_wr <= pcq_inc(pcq_wr);
                end
                if (live_data) begin
                    pcq_rd <= pcq_inc(pcq_rd);
                end
            end
        end
    end

    // Instruction buffer storage; cleared on reset so the bus reads zero
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(IBUF_DEPTH); i++) begin
                fifo_mem[i] <= '0;
            end
        end else if (push) begin
            fifo_mem[fifo_wr] <= push_data;
        end
    end

    // In-flight pc queue storage
    always_ff @(posedge clk) begin
        if (live_hs) begin
            pcq_mem[pcq_wr] <= inst_sram_addr;
        end
    end

    // Counter and buffer sanity checks
    always_ff @(posedge clk) begin
        if (resetn) begin
            assert (!(inst_sram_data_ok && outstanding == '0));
            assert (!(hs && !inst_sram_data_ok && 32'(outstanding) >= MAX_OUTSTANDING));
            assert (discard <= outstanding);
            assert (!(push && !pop && 32'(fifo_cnt) >= IBUF_DEPTH));
        end
    end

`ifdef IF_PERF_CNT_EN
    // Pops delivered to ID and responses thrown away after redirects
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_fetch_cnt <= 32'h0;
            perf_drop_cnt  <= 32'h0;
        end else begin
            perf_fetch_cnt <= perf_fetch_cnt + 32'(pop);
            perf_drop_cnt  <= perf_drop_cnt + 32'(drop);
        end
    end
`else
`endif

endmodule
